// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link, used by both the transmit and receive sides.
// Build option: TDM_DEMUX_PARITY_EN adds a fifth slot carrying the XOR of the four samples.
package tdm_pkg;

  localparam int TDM_NCH      = 4;
  localparam int TDM_PAR_SLOT = TDM_NCH;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int TDM_NSLOT  = TDM_NCH + 1;
  localparam int TDM_SLOT_W = 3;
`else
  localparam int TDM_NSLOT  = TDM_NCH;
  localparam int TDM_SLOT_W = 2;
`endif

  localparam logic [TDM_SLOT_W-1:0] TDM_LAST_SLOT = TDM_SLOT_W'(TDM_NSLOT - 1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_1x4_if.sv
// Serial-link input and parallel-channel output bundle of the TDM demultiplexer.
// The slot field widens to 3 bits when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_1x4_if
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic                      in_valid;
  logic                      in_sof;
  logic [DATA_W-1:0]         in_data;
  logic [TDM_NCH*DATA_W-1:0] out;
  logic                      out_valid;
  logic [TDM_SLOT_W-1:0]     slot;
  logic                      sync_err;
  logic                      par_err;

  // master: link driver plus channel consumers; slave: the demultiplexer itself
  modport master (
    output in_valid, in_sof, in_data,
    input  out, out_valid, slot, sync_err, par_err
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out, out_valid, slot, sync_err, par_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM link: load-to-1 on frame start, clear on loss of sync,
// and wrap to 0 after the last slot. Shared by transmitter and receiver.
module tdm_slot_ctr #(
  parameter int             W    = 2,
  parameter logic [W-1:0]   LAST = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load1,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] slot
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= W'(1);
    end else if (inc) begin
      slot <= (slot == LAST) ? '0 : slot + W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_1x4.sv
// Receive side of the 4-channel TDM link: aligns on in_sof, buffers one frame and
// publishes all channels at once. Build option: TDM_DEMUX_PARITY_EN (5th XOR parity slot).
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input logic             clk,
  input logic             rst,
  tdm_demux_1x4_if.slave  bus
);

  localparam logic [0:0] ST_HUNT = HUNT;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]                state;
  logic [0:0]                nxt_state;
  logic [TDM_SLOT_W-1:0]     slot;
  logic [DATA_W-1:0]         shadow [TDM_NCH];
  logic [1:0]                sh_idx;
  logic                      sh_wr;
  logic                      frame_end;
  logic                      sync_hit;
  logic                      ctr_load1;
  logic                      ctr_clr;
  logic                      ctr_inc;
  logic [TDM_NCH*DATA_W-1:0] out_q;
  logic                      out_valid_q;
  logic                      sync_err_q;

  tdm_slot_ctr #(
    .W    (TDM_SLOT_W),
    .LAST (TDM_LAST_SLOT)
  ) u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .slot  (slot)
  );

  // NOTE: every signal gets a default before the branches so no path leaves one unassigned (no latches).
  always_comb begin
    nxt_state = state;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;
    ctr_inc   = 1'b0;
    sh_wr     = 1'b0;
    sh_idx    = slot[1:0];
    frame_end = 1'b0;
    sync_hit  = 1'b0;
    if (bus.in_valid) begin
      if (state == ST_HUNT) begin
        if (bus.in_sof) begin
          nxt_state = ST_RUN;
          ctr_load1 = 1'b1;
          sh_wr     = 1'b1;
          sh_idx    = 2'd0;
        end
      end else if (bus.in_sof) begin
        // A marker mid-frame drops the partial frame and restarts at slot 0.
        sync_hit  = (slot != '0);
        ctr_load1 = 1'b1;
        sh_wr     = 1'b1;
        sh_idx    = 2'd0;
      end else if (slot == '0) begin
        sync_hit  = 1'b1;
        nxt_state = ST_HUNT;
        ctr_clr   = 1'b1;
      end else begin
        ctr_inc = 1'b1;
        if (slot == TDM_LAST_SLOT) begin
          frame_end = 1'b1;
        end else begin
          sh_wr = 1'b1;
        end
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic [DATA_W-1:0] par_calc;
  logic              par_err_q;

  always_comb begin
    par_calc = '0;
    for (int k = 0; k < TDM_NCH; k++) begin
      par_calc = par_calc ^ shadow[k];
    end
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: the shadow buffer is cleared on reset as well, so its contents are deterministic afterwards.
    if (rst) begin
      state       <= ST_HUNT;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int k = 0; k < TDM_NCH; k++) begin
        shadow[k] <= '0;
      end
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state       <= nxt_state;
      out_valid_q <= 1'b0;
      sync_err_q  <= sync_hit;
      if (sh_wr) begin
        shadow[sh_idx] <= bus.in_data;
      end
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q <= 1'b0;
      if (frame_end) begin
        if (bus.in_data == par_calc) begin
          out_q       <= {shadow[3], shadow[2], shadow[1], shadow[0]};
          out_valid_q <= 1'b1;
        end else begin
          par_err_q <= 1'b1;
        end
      end
`else
      if (frame_end) begin
        out_q       <= {bus.in_data, shadow[2], shadow[1], shadow[0]};
        out_valid_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot;
  assign bus.sync_err  = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err   = par_err_q;
`else
  assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: directed vector table for the framing corner cases, then
// random traffic compared against a queue-based frame model. Honours TDM_DEMUX_PARITY_EN.
module tb_tdm_demux_1x4;
  import tdm_pkg::*;

  localparam int W  = 4;
  localparam int OW = TDM_NCH * W;

  typedef struct packed {
    logic [OW-1:0]         out;
    logic                  ov;
    logic [TDM_SLOT_W-1:0] slot;
    logic                  se;
    logic                  pe;
  } obs_t;

  typedef struct {
    logic         r;
    logic         v;
    logic         s;
    logic [W-1:0] d;
    obs_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  tdm_demux_1x4_if #(.DATA_W(W)) bus ();

  tdm_demux_1x4 #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t         vecs[$];
  logic         m_aligned;
  logic [W-1:0] m_q[$];
  logic [OW-1:0] m_out;
  obs_t         m_exp;

  task automatic add(input logic r, v, s, input logic [W-1:0] d,
                     input logic [OW-1:0] eo, input logic ov, input int sl,
                     input logic se, input logic pe);
    vec_t x;
    x.r = r; x.v = v; x.s = s; x.d = d;
    x.exp.out  = eo;
    x.exp.ov   = ov;
    x.exp.slot = TDM_SLOT_W'(sl);
    x.exp.se   = se;
    x.exp.pe   = pe;
    vecs.push_back(x);
  endtask

  task automatic step(input logic r, v, s, input logic [W-1:0] d);
    rst          = r;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.out  = bus.out;
    o.ov   = bus.out_valid;
    o.slot = bus.slot;
    o.se   = bus.sync_err;
    o.pe   = bus.par_err;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got out=%h ov=%b slot=%0d sync=%b par=%b, want out=%h ov=%b slot=%0d sync=%b par=%b",
               name, act.out, act.ov, act.slot, act.se, act.pe,
               exp.out, exp.ov, exp.slot, exp.se, exp.pe);
    end
  endtask

  // Frame model: the queue holds the samples of the frame collected so far.
  task automatic model_step(input logic r, v, s, input logic [W-1:0] d);
    logic [W-1:0] x;
    logic         good;
    m_exp.ov = 1'b0;
    m_exp.se = 1'b0;
    m_exp.pe = 1'b0;
    if (r) begin
      m_aligned = 1'b0;
      m_q.delete();
      m_out = '0;
    end else if (v) begin
      if (!m_aligned) begin
        if (s) begin
          m_aligned = 1'b1;
          m_q.delete();
          m_q.push_back(d);
        end
      end else if (s) begin
        m_exp.se = (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_exp.se  = 1'b1;
        m_aligned = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == TDM_NSLOT) begin
          good = 1'b1;
          if (TDM_NSLOT > TDM_NCH) begin
            x = '0;
            for (int k = 0; k < TDM_NCH; k++) x = x ^ m_q[k];
            good = (x == m_q[TDM_NCH]);
          end
          if (good) begin
            for (int k = 0; k < TDM_NCH; k++) m_out[k*W +: W] = m_q[k];
            m_exp.ov = 1'b1;
          end else begin
            m_exp.pe = 1'b1;
          end
          m_q.delete();
        end
      end
    end
    m_exp.out  = m_out;
    m_exp.slot = TDM_SLOT_W'(m_q.size());
  endtask

  initial begin
    logic         r, v, s;
    logic [W-1:0] d;

`ifdef TDM_DEMUX_PARITY_EN
    add(1, 1, 1, 4'h1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 1, 4'h1, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 16'h0000, 0, 2, 0, 0);
    add(0, 1, 0, 4'h1, 16'h0000, 0, 3, 0, 0);
    add(0, 1, 0, 4'h1, 16'h0000, 0, 4, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 1, 0, 0, 0);
    add(0, 1, 1, 4'h1, 16'h1101, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 16'h1101, 0, 2, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 3, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 4, 0, 0);
    add(0, 1, 0, 4'h0, 16'h1101, 0, 0, 0, 1);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 0, 1, 0);
    add(0, 1, 1, 4'h0, 16'h1101, 0, 1, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 2, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 3, 0, 0);
    add(0, 1, 0, 4'h0, 16'h1101, 0, 4, 0, 0);
    add(0, 1, 1, 4'h1, 16'h1101, 0, 1, 1, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 2, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 3, 0, 0);
    add(0, 1, 0, 4'h0, 16'h1101, 0, 4, 0, 0);
    add(0, 1, 0, 4'h1, 16'h0111, 1, 0, 0, 0);
    add(0, 1, 1, 4'h1, 16'h0111, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 16'h0111, 0, 2, 0, 0);
    add(1, 0, 0, 4'h1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 0, 4'h1, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 16'h0000, 0, 0, 0, 0);
`else
    add(1, 1, 1, 4'h1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 1, 4'h1, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 16'h0000, 0, 2, 0, 0);
    add(0, 1, 0, 4'h1, 16'h0000, 0, 3, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 1, 0, 0, 0);
    add(0, 1, 1, 4'h0, 16'h1101, 0, 1, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 2, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 0, 3, 0, 0);
    add(0, 1, 0, 4'h0, 16'h0110, 1, 0, 0, 0);
    add(0, 1, 1, 4'h1, 16'h0110, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 16'h0110, 0, 2, 0, 0);
    add(0, 1, 1, 4'h1, 16'h0110, 0, 1, 1, 0);
    add(0, 1, 0, 4'h0, 16'h0110, 0, 2, 0, 0);
    add(0, 1, 0, 4'h0, 16'h0110, 0, 3, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1001, 1, 0, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1001, 0, 0, 1, 0);
    add(0, 1, 0, 4'h0, 16'h1001, 0, 0, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1001, 0, 0, 0, 0);
    add(0, 0, 1, 4'h1, 16'h1001, 0, 0, 0, 0);
    add(0, 1, 1, 4'h1, 16'h1001, 0, 1, 0, 0);
    for (int g = 0; g < 3; g++) add(0, 0, g == 0, 4'hF, 16'h1001, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 16'h1001, 0, 2, 0, 0);
    for (int g = 0; g < 3; g++) add(0, 0, 0, 4'hF, 16'h1001, 0, 2, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1001, 0, 3, 0, 0);
    for (int g = 0; g < 3; g++) add(0, 0, 0, 4'hF, 16'h1001, 0, 3, 0, 0);
    add(0, 1, 0, 4'h1, 16'h1101, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 16'h1101, 0, 0, 0, 0);
    add(0, 1, 1, 4'h0, 16'h1101, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 16'h1101, 0, 2, 0, 0);
    add(1, 1, 0, 4'h1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 0, 4'h1, 16'h0000, 0, 0, 0, 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d);
      check($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end

    step(1'b1, 1'b0, 1'b0, '0);
    model_step(1'b1, 1'b0, 1'b0, '0);
    check("rand_reset", sample(), m_exp);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      if (m_q.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                 s = ($urandom_range(0, 29) == 0);
      d = W'($urandom);
      if (m_q.size() == TDM_NCH && TDM_NSLOT > TDM_NCH && $urandom_range(0, 3) != 0) begin
        d = '0;
        foreach (m_q[k]) d = d ^ m_q[k];
      end
      step(r, v, s, d);
      model_step(r, v, s, d);
      check($sformatf("rand%0d", n), sample(), m_exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
